// File: rtl/modbus_frame_rx_var.sv
// rtl/modbus_frame_rx_var.sv - Modbus RTU request-frame parser with inline CRC-16 check
// and a word buffer for FC 0x10 payloads.
module modbus_frame_rx_var #(
   parameter logic [7:0] ADDR     = 8'h01,
   parameter bit         BCAST_EN = 1'b1,
   parameter int         MAX_REGS = 16,
   parameter int         IDX_W    = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rx_drop_frame,
   input  logic             rx_new_frame,
   input  logic             rx_done,
   input  logic [7:0]       rx_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [15:0]      rd_word,
   output logic             frame_valid,
   output logic             frame_err,
   output logic [2:0]       err_code,
   output logic             is_bcast,
   output logic [7:0]       func_code,
   output logic [15:0]      start_addr,
   output logic [15:0]      qty,
   output logic [15:0]      crc_rx_code
);

   localparam int PC_W  = IDX_W + 1;
   localparam int DEPTH = 2 ** IDX_W;

   typedef enum logic [3:0] {
      S_IDLE, S_FUNC, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_BCNT,
      S_PAY, S_CRCL, S_CRCH, S_CHECK, S_DONE, S_DRAIN
   } state_t;

   state_t            state_q, state_d, cur;
   logic              arm_q, arm_d;
   logic [15:0]       crc_q, crc_d, crc_upd;
   logic [PC_W-1:0]   pay_cnt_q, pay_cnt_d;
   logic              valid_q, valid_d, err_q, err_d;
   logic [2:0]        err_code_q, err_code_d;
   logic              bcast_q, bcast_d;
   logic [7:0]        func_q, func_d;
   logic [15:0]       saddr_q, saddr_d, qty_q, qty_d, qty_new;
   logic [15:0]       crc_rx_q, crc_rx_d;
   logic [15:0]       rd_word_q;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [15:0]       mem_q [DEPTH];

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   // The first byte of a frame always restarts the CRC from its init value.
   assign crc_upd = crc_step((cur == S_IDLE) ? 16'hFFFF : crc_q, rx_data);
   assign qty_new = {qty_q[15:8], rx_data};
   assign wr_idx  = pay_cnt_q[IDX_W:1];

   always_comb begin
      state_d    = state_q;
      arm_d      = arm_q;
      crc_d      = crc_q;
      pay_cnt_d  = pay_cnt_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      bcast_d    = bcast_q;
      func_d     = func_q;
      saddr_d    = saddr_q;
      qty_d      = qty_q;
      crc_rx_d   = crc_rx_q;
      wr_en      = 1'b0;
      cur        = state_q;

      if (rx_drop_frame && !(state_q inside {S_IDLE, S_DRAIN, S_DONE})) begin
         err_d      = 1'b1;
         err_code_d = 3'd4;
         cur        = S_DRAIN;
         state_d    = S_DRAIN;
      end
      // A silence pulse re-arms even when a byte lands in the same cycle.
      if (rx_new_frame) begin
         cur     = S_IDLE;
         state_d = S_IDLE;
         arm_d   = 1'b1;
      end

      case (cur)
         S_CHECK: begin
            state_d = S_DONE;
            if (crc_rx_q == crc_q) begin
               valid_d    = 1'b1;
               err_code_d = 3'd0;
            end else begin
               err_d      = 1'b1;
               err_code_d = 3'd3;
            end
         end
         S_DONE: state_d = S_DRAIN;
         default: begin
            if (rx_done) begin
               case (cur)
                  S_IDLE: begin
                     if (arm_d) begin
                        arm_d = 1'b0;
                        crc_d = crc_upd;
                        if (rx_data == ADDR || (BCAST_EN && rx_data == 8'h00)) begin
                           state_d = S_FUNC;
                           bcast_d = (rx_data == 8'h00);
                        end else begin
                           state_d = S_DRAIN;
                        end
                     end
                  end
                  S_FUNC: begin
                     crc_d  = crc_upd;
                     func_d = rx_data;
                     if (rx_data inside {8'h03, 8'h04, 8'h06, 8'h10}) begin
                        state_d = S_HDR0;
                     end else begin
                        err_d      = 1'b1;
                        err_code_d = 3'd1;
                        state_d    = S_DRAIN;
                     end
                  end
                  S_HDR0: begin
                     crc_d         = crc_upd;
                     saddr_d[15:8] = rx_data;
                     state_d       = S_HDR1;
                  end
                  S_HDR1: begin
                     crc_d        = crc_upd;
                     saddr_d[7:0] = rx_data;
                     state_d      = S_HDR2;
                  end
                  S_HDR2: begin
                     crc_d       = crc_upd;
                     qty_d[15:8] = rx_data;
                     state_d     = S_HDR3;
                  end
                  S_HDR3: begin
                     crc_d      = crc_upd;
                     qty_d[7:0] = rx_data;
                     if (func_q != 8'h10) begin
                        state_d = S_CRCL;
                     end else if (qty_new == 16'h0000 || qty_new > 16'(MAX_REGS)) begin
                        err_d      = 1'b1;
                        err_code_d = 3'd2;
                        state_d    = S_DRAIN;
                     end else begin
                        state_d = S_BCNT;
                     end
                  end
                  S_BCNT: begin
                     crc_d = crc_upd;
                     if ({qty_q, 1'b0} != {9'd0, rx_data}) begin
                        err_d      = 1'b1;
                        err_code_d = 3'd2;
                        state_d    = S_DRAIN;
                     end else begin
                        pay_cnt_d = '0;
                        state_d   = S_PAY;
                     end
                  end
                  S_PAY: begin
                     crc_d     = crc_upd;
                     wr_en     = 1'b1;
                     pay_cnt_d = pay_cnt_q + PC_W'(1);
                     if (17'(pay_cnt_q) + 17'd1 == {qty_q, 1'b0}) begin
                        state_d = S_CRCL;
                     end
                  end
                  S_CRCL: begin
                     crc_rx_d[7:0] = rx_data;
                     state_d       = S_CRCH;
                  end
                  S_CRCH: begin
                     crc_rx_d[15:8] = rx_data;
                     state_d        = S_CHECK;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         arm_q      <= 1'b1;
         crc_q      <= 16'hFFFF;
         pay_cnt_q  <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 3'd0;
         bcast_q    <= 1'b0;
         func_q     <= 8'h00;
         saddr_q    <= 16'h0000;
         qty_q      <= 16'h0000;
         crc_rx_q   <= 16'h0000;
         rd_word_q  <= 16'h0000;
      end else begin
         state_q    <= state_d;
         arm_q      <= arm_d;
         crc_q      <= crc_d;
         pay_cnt_q  <= pay_cnt_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         bcast_q    <= bcast_d;
         func_q     <= func_d;
         saddr_q    <= saddr_d;
         qty_q      <= qty_d;
         crc_rx_q   <= crc_rx_d;
         rd_word_q  <= mem_q[rd_idx];
      end
   end

   // Payload storage needs no reset; only words written by the current frame are meaningful.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         if (pay_cnt_q[0]) mem_q[wr_idx][7:0]  <= rx_data;
         else              mem_q[wr_idx][15:8] <= rx_data;
      end
   end

   assign rd_word     = rd_word_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign err_code    = err_code_q;
   assign is_bcast    = bcast_q;
   assign func_code   = func_q;
   assign start_addr  = saddr_q;
   assign qty         = qty_q;
   assign crc_rx_code = crc_rx_q;

endmodule

// File: tb/tb_modbus_frame_rx_var.sv
// tb/tb_modbus_frame_rx_var.sv - directed and randomized frames against a frame-level
// reference model; every cycle's pulses are compared with the model's schedule.
module tb_modbus_frame_rx_var;

   localparam logic [7:0] ADDR     = 8'h01;
   localparam bit         BCAST_EN = 1'b1;
   localparam int         MAX_REGS = 16;
   localparam int         IDX_W    = 4;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic             rx_drop_frame = 1'b0, rx_new_frame = 1'b0, rx_done = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic [IDX_W-1:0] rd_idx = '0;
   logic [15:0]      rd_word, start_addr, qty, crc_rx_code;
   logic             frame_valid, frame_err, is_bcast;
   logic [2:0]       err_code;
   logic [7:0]       func_code;

   modbus_frame_rx_var #(.ADDR(ADDR), .BCAST_EN(BCAST_EN), .MAX_REGS(MAX_REGS), .IDX_W(IDX_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rx_drop_frame(rx_drop_frame), .rx_new_frame(rx_new_frame),
      .rx_done(rx_done), .rx_data(rx_data), .rd_idx(rd_idx), .rd_word(rd_word),
      .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code), .is_bcast(is_bcast),
      .func_code(func_code), .start_addr(start_addr), .qty(qty), .crc_rx_code(crc_rx_code)
   );

   always #5 clk_in = ~clk_in;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int kind; int idx; int lat; logic [2:0] code;
      logic [7:0] fc; logic [15:0] sa; logic [15:0] q; logic [15:0] crc; logic bc;
   } out_t;
   typedef struct {int cyc; out_t o;} ev_t;

   int   cyc = 0;
   int   total = 0, bad = 0;
   int   n_valid = 0, n_err = 0;
   ev_t  evq[$];

   always @(posedge clk_in) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] crc16(input bq_t b, input int n);
      logic [15:0] c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   // Outcome of a complete frame: which byte triggers the single pulse, and what it carries.
   function automatic out_t model(input bq_t b);
      out_t o;
      int pos;
      o.kind = 0; o.idx = -1; o.lat = 1; o.code = 3'd0; o.fc = 8'h00;
      o.sa = 16'h0; o.q = 16'h0; o.crc = 16'h0; o.bc = 1'b0;
      if (!(b[0] == ADDR || (BCAST_EN && b[0] == 8'h00))) return o;
      o.bc = (b[0] == 8'h00);
      o.fc = b[1];
      if (!(b[1] inside {8'h03, 8'h04, 8'h06, 8'h10})) begin
         o.kind = 2; o.code = 3'd1; o.idx = 1; return o;
      end
      o.sa = {b[2], b[3]};
      o.q  = {b[4], b[5]};
      pos  = 6;
      if (b[1] == 8'h10) begin
         if (o.q == 16'h0 || int'(o.q) > MAX_REGS) begin
            o.kind = 2; o.code = 3'd2; o.idx = 5; return o;
         end
         if (int'(b[6]) != 2 * int'(o.q)) begin
            o.kind = 2; o.code = 3'd2; o.idx = 6; return o;
         end
         pos = 7 + 2 * int'(o.q);
      end
      o.crc  = {b[pos+1], b[pos]};
      o.idx  = pos + 1;
      o.lat  = 2;
      o.code = 3'd3;
      o.kind = (o.crc == crc16(b, pos)) ? 1 : 2;
      return o;
   endfunction

   always @(negedge clk_in) begin : cmp
      int   k;
      ev_t  e;
      k = 0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
         e = evq.pop_front();
         k = e.o.kind;
      end
      if (frame_valid) n_valid++;
      if (frame_err)   n_err++;
      chk("frame_valid", 32'(frame_valid), 32'(k == 1));
      chk("frame_err", 32'(frame_err), 32'(k == 2));
      if (k == 2) chk("err_code", 32'(err_code), 32'(e.o.code));
      if (k == 1) begin
         chk("err_code_at_valid", 32'(err_code), 32'd0);
         chk("func_code", 32'(func_code), 32'(e.o.fc));
         chk("start_addr", 32'(start_addr), 32'(e.o.sa));
         chk("qty", 32'(qty), 32'(e.o.q));
         chk("crc_rx_code", 32'(crc_rx_code), 32'(e.o.crc));
         chk("is_bcast", 32'(is_bcast), 32'(e.o.bc));
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_word"}, 32'(rd_word), 32'd0);
      chk({tag, "_valid"}, 32'(frame_valid), 32'd0);
      chk({tag, "_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_err_code"}, 32'(err_code), 32'd0);
      chk({tag, "_bcast"}, 32'(is_bcast), 32'd0);
      chk({tag, "_func"}, 32'(func_code), 32'd0);
      chk({tag, "_saddr"}, 32'(start_addr), 32'd0);
      chk({tag, "_qty"}, 32'(qty), 32'd0);
      chk({tag, "_crc"}, 32'(crc_rx_code), 32'd0);
   endtask

   task automatic send_frame(input bq_t b, input int abort_at, input int rst_at, input bit combine,
                             output out_t o, output bit ab_eff);
      ev_t e;
      o      = model(b);
      ab_eff = (abort_at >= 1) && (o.kind != 0) && (o.idx >= abort_at);
      if (!combine) begin
         rx_new_frame = 1'b1; step(); rx_new_frame = 1'b0;
      end
      for (int i = 0; i < b.size(); i++) begin
         if (i == rst_at) begin
            rst_in = 1'b1;
            #1;
            chk_all_zero("midrst");
            step();
            rst_in = 1'b0;
            return;
         end
         if (i == abort_at) begin
            rx_drop_frame = 1'b1;
            if (ab_eff) begin
               e.cyc = cyc + 1; e.o = o; e.o.kind = 2; e.o.code = 3'd4;
               evq.push_back(e);
            end
            step();
            rx_drop_frame = 1'b0;
         end
         repeat ($urandom_range(0, 2)) step();
         rx_done = 1'b1;
         rx_data = b[i];
         if (i == 0 && combine) rx_new_frame = 1'b1;
         if (i == o.idx && !ab_eff) begin
            e.cyc = cyc + o.lat; e.o = o;
            evq.push_back(e);
         end
         step();
         rx_done = 1'b0;
         rx_new_frame = 1'b0;
      end
      repeat (4) step();
   endtask

   function automatic bq_t q8(input logic [63:0] v);
      bq_t b;
      for (int i = 0; i < 8; i++) b.push_back(v[63-8*i -: 8]);
      return b;
   endfunction

   function automatic bq_t build(input logic [7:0] a, input logic [7:0] fc, input logic [15:0] sa,
                                 input logic [15:0] q, input bq_t extra);
      bq_t b;
      logic [15:0] c;
      b.push_back(a); b.push_back(fc);
      b.push_back(sa[15:8]); b.push_back(sa[7:0]);
      b.push_back(q[15:8]); b.push_back(q[7:0]);
      foreach (extra[i]) b.push_back(extra[i]);
      c = crc16(b, b.size());
      b.push_back(c[7:0]); b.push_back(c[15:8]);
      return b;
   endfunction

   function automatic bq_t gen_frame();
      bq_t ex, b;
      logic [7:0] a, fc;
      logic [15:0] q;
      int r, np;
      r = $urandom_range(0, 9);
      a = (r == 0) ? 8'h00 : (r == 1) ? 8'($urandom_range(2, 247)) : ADDR;
      if ($urandom_range(0, 9) == 0) begin
         do fc = 8'($urandom); while (fc inside {8'h03, 8'h04, 8'h06, 8'h10});
      end else begin
         r = $urandom_range(0, 3);
         fc = (r == 0) ? 8'h03 : (r == 1) ? 8'h04 : (r == 2) ? 8'h06 : 8'h10;
      end
      q = 16'($urandom);
      if (fc == 8'h10) begin
         r = $urandom_range(0, 9);
         q = (r == 0) ? 16'd0 : (r == 1) ? 16'($urandom_range(MAX_REGS + 1, 40)) :
             16'($urandom_range(1, MAX_REGS));
         ex.push_back(8'(2 * int'(q) + (($urandom_range(0, 9) == 0) ? 1 : 0)));
         np = (int'(q) <= MAX_REGS) ? 2 * int'(q) : 4;
         for (int i = 0; i < np; i++) ex.push_back(8'($urandom));
      end
      b = build(a, fc, 16'($urandom), q, ex);
      if ($urandom_range(0, 6) == 0) b[b.size() - 1 - $urandom_range(0, 1)] ^= 8'(1 << $urandom_range(0, 7));
      return b;
   endfunction

   initial begin : main
      bq_t  b, ex;
      out_t o;
      bit   ab;
      int   v0, e0, ab_at;

      repeat (3) step();
      chk_all_zero("reset");
      rst_in = 1'b0;
      step();
      chk_all_zero("post_reset");

      chk("model_crc_fc03", 32'(crc16(q8(64'h0103_0000_000A_C5CD), 6)), 32'h0000CDC5);
      chk("model_crc_fc06", 32'(crc16(q8(64'h0106_0001_0003_980B), 6)), 32'h00000B98);

      v0 = n_valid; e0 = n_err;
      send_frame(q8(64'h0103_0000_000A_C5CD), -1, -1, 1'b0, o, ab);
      chk("fc03_valid_count", 32'(n_valid - v0), 32'd1);
      chk("fc03_func", 32'(func_code), 32'h03);
      chk("fc03_saddr", 32'(start_addr), 32'h0000);
      chk("fc03_qty", 32'(qty), 32'h000A);
      chk("fc03_crc", 32'(crc_rx_code), 32'hCDC5);

      v0 = n_valid;
      send_frame(q8(64'h0106_0001_0003_980B), -1, -1, 1'b1, o, ab);
      chk("fc06_valid_count", 32'(n_valid - v0), 32'd1);
      chk("fc06_qty", 32'(qty), 32'h0003);

      e0 = n_err;
      send_frame(q8(64'h0106_0001_0003_980C), -1, -1, 1'b0, o, ab);
      chk("fc06_badcrc_err_count", 32'(n_err - e0), 32'd1);
      chk("fc06_badcrc_code", 32'(err_code), 32'd3);

      ex = {};
      ex.push_back(8'h04); ex.push_back(8'h00); ex.push_back(8'h0A);
      ex.push_back(8'h01); ex.push_back(8'h02);
      v0 = n_valid;
      send_frame(build(8'h01, 8'h10, 16'h0000, 16'h0002, ex), -1, -1, 1'b0, o, ab);
      chk("fc10_valid_count", 32'(n_valid - v0), 32'd1);
      rd_idx = 4'd0; step();
      chk("fc10_word0", 32'(rd_word), 32'h000A);
      rd_idx = 4'd1; step();
      chk("fc10_word1", 32'(rd_word), 32'h0102);

      ex[0] = 8'h05;
      e0 = n_err;
      send_frame(build(8'h01, 8'h10, 16'h0000, 16'h0002, ex), -1, -1, 1'b0, o, ab);
      chk("fc10_bcnt_err_count", 32'(n_err - e0), 32'd1);
      chk("fc10_bcnt_code", 32'(err_code), 32'd2);

      ex = {};
      ex.push_back(8'd34);
      for (int i = 0; i < 34; i++) ex.push_back(8'(i));
      e0 = n_err;
      send_frame(build(8'h01, 8'h10, 16'h0010, 16'd17, ex), -1, -1, 1'b0, o, ab);
      chk("fc10_qty17_err_count", 32'(n_err - e0), 32'd1);
      chk("fc10_qty17_code", 32'(err_code), 32'd2);

      ex = {};
      v0 = n_valid; e0 = n_err;
      send_frame(build(8'h02, 8'h03, 16'h0000, 16'h000A, ex), -1, -1, 1'b0, o, ab);
      chk("other_slave_pulses", 32'(n_valid - v0 + n_err - e0), 32'd0);
      send_frame(q8(64'h0103_0000_000A_C5CD), -1, -1, 1'b0, o, ab);
      chk("after_other_valid", 32'(n_valid - v0), 32'd1);

      v0 = n_valid;
      send_frame(build(8'h00, 8'h06, 16'h0005, 16'h1234, ex), -1, -1, 1'b0, o, ab);
      chk("bcast_valid_count", 32'(n_valid - v0), 32'd1);
      chk("bcast_flag", 32'(is_bcast), 32'd1);

      e0 = n_err;
      send_frame(build(8'h01, 8'h05, 16'h0000, 16'hFF00, ex), -1, -1, 1'b0, o, ab);
      chk("fc05_err_count", 32'(n_err - e0), 32'd1);
      chk("fc05_code", 32'(err_code), 32'd1);

      e0 = n_err;
      send_frame(q8(64'h0103_0000_000A_C5CD), 4, -1, 1'b0, o, ab);
      chk("abort_err_count", 32'(n_err - e0), 32'd1);
      chk("abort_code", 32'(err_code), 32'd4);

      ex = {};
      ex.push_back(8'h08);
      for (int i = 0; i < 8; i++) ex.push_back(8'(8'hA0 + i));
      send_frame(build(8'h01, 8'h10, 16'h0100, 16'h0004, ex), -1, 10, 1'b0, o, ab);
      v0 = n_valid;
      send_frame(q8(64'h0103_0000_000A_C5CD), -1, -1, 1'b0, o, ab);
      chk("after_rst_valid_count", 32'(n_valid - v0), 32'd1);
      chk("after_rst_qty", 32'(qty), 32'h000A);

      for (int n = 0; n < 250; n++) begin
         b = gen_frame();
         ab_at = ($urandom_range(0, 6) == 0) ? $urandom_range(1, b.size() - 1) : -1;
         send_frame(b, ab_at, -1, ($urandom_range(0, 4) == 0), o, ab);
         if (o.kind == 1 && o.fc == 8'h10 && !ab) begin
            for (int k = 0; k < int'(o.q); k++) begin
               rd_idx = IDX_W'(k);
               step();
               chk("rand_rd_word", 32'(rd_word), 32'({b[7+2*k], b[8+2*k]}));
            end
         end
      end

      repeat (4) step();
      chk("events_drained", 32'(evq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
